surf_dout_framer: RTL
=====================

Name: surf_dout_framer

Overview:
- SURF-side transmitter for the DOUT link: turns an event byte stream into the 8-bit-per-sysclk word stream that feeds the DOUT OSERDES.
- The TURFIO receives this stream through its COUT/DOUT ISERDES path and deskews it with the training pattern.
- Sends the 32-bit training sequence while training is requested. Otherwise sends idle bytes, or start-delimited event frames aligned to 4-byte word boundaries set by sync.

Parameters:
- TRAIN_SEQUENCE, 32'hA55A6996, training word; sent MSB byte first.
- IDLE_BYTE, 8'h00, byte sent when no frame is in progress, and as pad after a frame.
- START_BYTE, 8'hFE, delimiter byte that immediately precedes each frame's payload.
- ERR_BYTE, 8'hEE, byte substituted for missing payload on upstream underflow.

Ports:
- sysclk_i  in  1  system clock; all logic is in this domain.
- sysclk_rst_i  in  1  synchronous, active-high reset.
- sync_i  in  1  single-cycle pulse; forces word phase to 0 on the next cycle.
- train_i  in  1  level; request to send the training sequence.
- frame_avail_i  in  1  upstream packet FIFO holds at least one complete frame.
- s_dout_tdata  in  8  payload byte.
- s_dout_tvalid  in  1  payload valid.
- s_dout_tready  out  1  payload accept.
- s_dout_tlast  in  1  last payload byte of the frame.
- dout_data_o  out  8  byte to the OSERDES; registered.
- training_o  out  1  high while TRAIN words are being sent.
- underflow_o  out  1  sticky flag: tvalid was low mid-frame.
- clr_underflow_i  in  1  clears underflow_o.
- frame_count_o  out  16  number of completed frames; wraps.

Behaviour:
- Reset values: dout_data_o=IDLE_BYTE, training_o=0, underflow_o=0, frame_count_o=0, s_dout_tready=0, phase=0, state=IDLE.
- Word phase:
  - phase is a 2-bit counter that increments every cycle.
  - sync_i forces phase to 0 on the next cycle. If sync arrives mid-frame, the frame is not aborted; padding realigns to the new phase.
  - A word boundary is a cycle where phase==0.
- State machine (IDLE, TRAIN, START, DATA, DRAIN, PAD):
  - IDLE: emit IDLE_BYTE.
    - At a boundary with train_i=1: go to TRAIN. train_i has priority.
    - Else at a boundary with frame_avail_i=1: go to START.
  - TRAIN: emit TRAIN_SEQUENCE byte [31-8*phase -: 8]; training_o=1.
    - At a boundary with train_i=0: go to IDLE.
    - train_i is sampled only at boundaries, so whole words are always sent.
  - START: emit START_BYTE for one cycle and assert s_dout_tready; go to DATA.
  - DATA: s_dout_tready=1.
    - If tvalid=1: dout_data_o <= tdata on the next cycle (1-cycle latency, no bubbles).
    - If tlast=1 on the accepted byte: increment frame_count_o and go to PAD.
    - If tvalid=0: emit ERR_BYTE, set underflow_o, and go to DRAIN.
  - DRAIN: s_dout_tready=1; emit IDLE_BYTE; discard bytes until tlast is accepted, then go to PAD.
    - frame_count_o does not increment for a drained frame.
  - PAD: emit IDLE_BYTE until the next boundary, then take the IDLE decision for that boundary in the same cycle.
    - If the frame ended exactly before a boundary, PAD has zero length: a back-to-back START is allowed at that boundary.
- A train_i assertion during START, DATA or DRAIN is deferred until the frame ends and PAD reaches a boundary.
- clr_underflow_i and a new underflow in the same cycle: set wins.
- frame_count_o wraps from 16'hFFFF to 0.
- Reset mid-frame: all state returns to reset values on the next cycle. Upstream must be reset with it; no drain is performed.

Decomposition:
- Shared package surf_dout_pkg:
  - state enum;
  - default IDLE_BYTE / START_BYTE / ERR_BYTE constants, shared with the TURFIO deframer;
  - TRAIN_SEQUENCE default.
- Single module with no sub-modules. The phase counter and the byte mux stay inline.

Test Plan:
- Reset, then no input for 16 cycles -> dout_data_o=00 every cycle; tready=0; frame_count_o=0.
- train_i=1 with a sync pulse -> repeating A5,5A,69,96 starting at phase 0.
  - Dropping train_i at phase 2 -> the current word completes (69,96), then 00.
- frame_avail_i=1 with 5-byte frame 01..05 starting at phase 3 -> 00 until the boundary.
  - Then FE,01,02,03,04,05, then 00,00 pad to the next boundary; frame_count_o=1.
- Two 3-byte frames back-to-back -> FE,a,b,c,FE,d,e,f with no pad; frame_count_o=2.
- tvalid drops after the 2nd of 4 bytes -> EE emitted and underflow_o=1.
  - Remaining bytes are drained; frame_count_o is unchanged.
  - clr_underflow_i clears the flag.
- train_i asserted mid-frame -> frame completes and pads; TRAIN starts at the next boundary.
  - sysclk_rst_i asserted mid-frame -> dout_data_o=00 on the next cycle and all counters cleared.

Source files
------------

// File: rtl/surf_dout_pkg.sv
// Shared DOUT link definitions: framer states, delimiter/idle/error bytes and training word.
// The byte constants are also used by the TURFIO-side deframer and must stay in step with it.
package surf_dout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_START,
        ST_DATA,
        ST_DRAIN,
        ST_PAD
    } state_e;

    localparam logic [31:0] DEF_TRAIN_SEQUENCE = 32'hA55A6996;
    localparam logic [7:0]  DEF_IDLE_BYTE      = 8'h00;
    localparam logic [7:0]  DEF_START_BYTE     = 8'hFE;
    localparam logic [7:0]  DEF_ERR_BYTE       = 8'hEE;

    // Byte of the training word sent at a given word phase, MSB byte at phase 0.
    function automatic logic [7:0] train_byte(input logic [31:0] seq, input logic [1:0] ph);
        logic [31:0] sh;
        sh = seq >> {(2'd3 - ph), 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/surf_dout_framer.sv
// DOUT framer: training words, idle, or word-aligned START+payload frames; one registered byte per sysclk.
// Payload lands on dout_data_o one cycle after acceptance; tready is high through START/DATA/DRAIN, never stalls.
module surf_dout_framer
    import surf_dout_pkg::*;
#(
    parameter logic [31:0] TRAIN_SEQUENCE = DEF_TRAIN_SEQUENCE,
    parameter logic [7:0]  IDLE_BYTE      = DEF_IDLE_BYTE,
    parameter logic [7:0]  START_BYTE     = DEF_START_BYTE,
    parameter logic [7:0]  ERR_BYTE       = DEF_ERR_BYTE
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        sync_i,
    input  logic        train_i,
    input  logic        frame_avail_i,
    input  logic [7:0]  s_dout_tdata,
    input  logic        s_dout_tvalid,
    output logic        s_dout_tready,
    input  logic        s_dout_tlast,
    output logic [7:0]  dout_data_o,
    output logic        training_o,
    output logic        underflow_o,
    input  logic        clr_underflow_i,
    output logic [15:0] frame_count_o
);

    state_e      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  dout_q, dout_d;
    logic        training_q, training_d;
    logic        underflow_q, underflow_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        boundary;
    logic        use_data;
    logic        use_err;

    assign s_dout_tready = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_DRAIN);

    // Decisions look one cycle ahead so the chosen byte is on the output exactly at phase 0.
    always_comb begin
        phase_d     = sync_i ? 2'd0 : phase_q + 2'd1;
        boundary    = (phase_d == 2'd0);
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        underflow_d = underflow_q & ~clr_underflow_i;
        use_data    = 1'b0;
        use_err     = 1'b0;

        case (state_q)
            ST_IDLE, ST_PAD: begin
                if (boundary) begin
                    if (train_i)            state_d = ST_TRAIN;
                    else if (frame_avail_i) state_d = ST_START;
                    else                    state_d = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (boundary && !train_i) state_d = ST_IDLE;
            end
            ST_START, ST_DATA: begin
                if (s_dout_tvalid) begin
                    use_data = 1'b1;
                    if (s_dout_tlast) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_PAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    use_err     = 1'b1;
                    underflow_d = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s_dout_tvalid && s_dout_tlast) state_d = ST_PAD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (use_data)                   dout_d = s_dout_tdata;
        else if (use_err)               dout_d = ERR_BYTE;
        else if (state_d == ST_TRAIN)   dout_d = train_byte(TRAIN_SEQUENCE, phase_d);
        else if (state_d == ST_START)   dout_d = START_BYTE;
        else                            dout_d = IDLE_BYTE;

        training_d = (state_d == ST_TRAIN);
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            dout_q      <= IDLE_BYTE;
            training_q  <= 1'b0;
            underflow_q <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dout_q      <= dout_d;
            training_q  <= training_d;
            underflow_q <= underflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dout_data_o   = dout_q;
    assign training_o    = training_q;
    assign underflow_o   = underflow_q;
    assign frame_count_o = frame_cnt_q;

endmodule
